// File: rtl/mac_divider.sv
// Iterative restoring divider: DD (2P bits) / BB (P bits) -> QQ, RR.
// Produces one quotient bit per clock with a start/busy/done handshake.
module mac_divider #(
  parameter int P = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*P-1:0] DD,
  input  logic [P-1:0]   BB,
  output logic           busy,
  output logic           done,
  output logic [2*P-1:0] QQ,
  output logic [P-1:0]   RR,
  output logic           div_zero
);

  localparam int CW = $clog2(2*P);
  localparam logic [CW-1:0] LAST = CW'(2*P-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state;
  logic [2*P-1:0] dvd;
  logic [2*P-1:0] quo;
  logic [P-1:0]   dvs;
  logic [P:0]     rem;
  logic [CW-1:0]  cnt;

  logic [P:0]     rem_shift;
  logic [P:0]     rem_nxt;
  logic [2*P-1:0] quo_nxt;
  logic           qbit;

  // P+1-bit remainder keeps the compare exact for divisors near 2^P-1
  always_comb begin
    rem_shift = {rem[P-1:0], dvd[2*P-1]};
    qbit      = (rem_shift >= {1'b0, dvs});
    rem_nxt   = qbit ? (rem_shift - {1'b0, dvs}) : rem_shift;
    quo_nxt   = {quo[2*P-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      QQ       <= '0;
      RR       <= '0;
      div_zero <= 1'b0;
      dvd      <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            if (BB == '0) begin
              QQ       <= '1;
              RR       <= DD[P-1:0];
              div_zero <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_DONE;
            end else begin
              dvd   <= DD;
              dvs   <= BB;
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          dvd <= {dvd[2*P-2:0], 1'b0};
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          // last iteration publishes the freshly computed bit directly
          if (cnt == LAST) begin
            QQ       <= quo_nxt;
            RR       <= rem_nxt[P-1:0];
            div_zero <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
